// File: rtl/bcd_scan4_if.sv
// Display-side bundle for the four-digit scanner: digit/dp requests in,
// decoder code, active-low anodes, decimal point and slot tick out.
interface bcd_scan4_if;
  logic [15:0] x;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [3:0]  d;
  logic [3:0]  an;
  logic        dp;
  logic        tick;

  modport master (
    output x, dp_in, lzb,
    input  d, an, dp, tick
  );

  modport slave (
    input  x, dp_in, lzb,
    output d, an, dp, tick
  );
endinterface

// File: rtl/bcd_scan4.sv
// Four-digit multiplexed display scanner: per-frame snapshot of BCD digits,
// one blank cycle per slot for anti-ghosting, optional leading-zero blanking.
module bcd_scan4 #(
  parameter int DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  bcd_scan4_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   snap_reg;
  logic [3:0]    dps_reg;
  logic          lzb_reg;
  logic          tick;
  logic          en;
  logic [3:0]    nz;
  logic [3:0]    blank;

  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      idx_reg  <= 2'd0;
      snap_reg <= 16'h0000;
      dps_reg  <= 4'h0;
      lzb_reg  <= 1'b0;
    end else begin
      // lzb is registered so no input reaches an output combinationally
      lzb_reg <= bus.lzb;
      if (tick) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
        if (idx_reg == 2'd3) begin
          snap_reg <= bus.x;
          dps_reg  <= bus.dp_in;
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // A digit is blanked when it and every more-significant digit are zero
  for (genvar gi = 0; gi < 4; gi++) begin : g_nz
    assign nz[gi] = (snap_reg[4*gi +: 4] == 4'd0);
  end

  assign blank[3] = nz[3];
  for (genvar gi = 1; gi < 3; gi++) begin : g_blank
    assign blank[gi] = nz[gi] & blank[gi+1];
  end
  assign blank[0] = 1'b0;

  assign en       = (cnt_reg != '0) && !(lzb_reg && blank[idx_reg]);
  assign bus.d    = snap_reg[{idx_reg, 2'b00} +: 4];
  assign bus.tick = tick;

  always_comb begin
    bus.an = 4'hF;
    bus.dp = 1'b1;
    if (en) begin
      bus.an[idx_reg] = 1'b0;
      bus.dp          = ~dps_reg[idx_reg];
    end
  end
endmodule

// File: doc/bcd_scan4.md
# bcd_scan4

Four-digit multiplexed display scanner. It sits directly upstream of the BCD to 7-segment decoder and time-multiplexes four BCD digits onto that decoder's single 4-bit `d` input. It drives the active-low digit-enable (anode) lines and the decimal point of a common-anode 4-digit display. Input digits are snapshotted once per scan frame, so a displayed frame never mixes old and new values.

## Interface
Parameters:
- `DIV`, default 50000: clock cycles per digit slot (50 MHz gives 1 kHz per digit, 250 Hz per frame). Legal range is DIV ≥ 2.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `x`  in  16: four BCD digits. `x[3:0]` is digit 0 (least significant); `x[15:12]` is digit 3.
- `dp_in`  in  4: decimal point request per digit, active-high. Bit i belongs to digit i.
- `lzb`  in  1: leading-zero blanking enable.
- `d`  out  4: BCD code of the current digit. Connects to the decoder's `d`.
- `an`  out  4: digit enables, active-low. At most one bit is low at any time.
- `dp`  out  1: decimal point segment, active-low.
- `tick`  out  1: one-cycle pulse on the last cycle of each digit slot.

## Operation
- State:
  - prescaler `cnt`, width clog2(DIV)
  - digit index `idx`, 2 bits
  - digit snapshot `snap`, 16 bits
  - decimal-point snapshot `dps`, 4 bits
- Prescaler:
  - `cnt` counts 0..DIV-1 and wraps to 0.
  - `tick` = (cnt == DIV-1).
  - On each tick edge, `idx` advances by 1 and wraps 3→0.
- Snapshot:
  - `snap` and `dps` load `x` and `dp_in` on the edge where tick=1 and idx=3, i.e. at the 3→0 wrap.
  - Digit 0 of the new frame is the first digit shown from the new values.
  - Changes to `x` at any other time are not visible until the next frame.
- Outputs are decoded from registered state only. There is no combinational path from `x`, `dp_in` or `lzb` to any output.
- `d` = snap[4·idx+3 : 4·idx]. Non-BCD codes (10..15) pass through unchanged; the decoder owns their rendering.
- Anti-ghosting:
  - While cnt == 0, all of `an` = 4'b1111 and `dp` = 1.
  - For cnt ≥ 1, `an[idx]` = 0 unless the current digit is blanked.
- Leading-zero blanking, when `lzb` = 1:
  - Digit i ≥ 1 is blanked when snap digit i and all more-significant snap digits equal 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its `an` bit at 1 and forces `dp` = 1.
  - `lzb` is sampled live each cycle; it is not snapshotted.
- `dp` = ~dps[idx] when the digit is enabled, else 1.

## Timing
- Reset values (effective on the first edge with reset=1):
  - cnt=0, idx=0, snap=0, dps=0.
  - Outputs: d=0, an=4'b1111, dp=1, tick=0.
- Reset has priority over every other update. Reset asserted mid-slot or mid-frame aborts the scan and restarts at digit 0 with the blank cycle. The snapshot is cleared, so `0000` is shown until the first frame wrap.
- Slot length is exactly DIV cycles: 1 blank cycle followed by DIV-1 enabled cycles. Frame length is 4·DIV cycles.
- `idx`, `d` and `an` change on the same edge, which is the edge where cnt returns to 0.
- Snapshot latency: a value of `x` that is stable at a wrap edge is driven on `d` from that edge onward. Worst-case delay from an `x` change to display is 4·DIV cycles.
- When `x` changes on the same cycle as the wrap edge, the value sampled at that edge is used; standard setup applies.
- DIV=2: each slot is 1 blank cycle plus 1 enabled cycle, and `tick` is high every other cycle.

## Test plan
All scenarios use DIV=4.
- Reset, then hold x=16'h1234 and dp_in=0 for 40 cycles.
  - First frame (cycles 0–15 after reset release): d=0, an cycles 1110/1101/1011/0111 after each blank.
  - From cycle 16: d sequence 4,3,2,1 per 4-cycle slot.
  - an is 1111 on every cnt=0 cycle.
  - tick pulses every 4 cycles.
- Change x from 16'h1234 to 16'h5678 mid-frame, while digit 1 is shown.
  - The remaining digits of the current frame still show 2,1.
  - From the next wrap: 8,7,6,5.
- Set x=16'h0050 and lzb=1.
  - Digits 3 and 2 have an=1111 for the whole slot.
  - Digit 1 shows d=5 with an=1101.
  - Digit 0 shows d=0 with an=1110.
  - With lzb=0, all four digits are enabled.
- Set x=16'h0000, lzb=1, dp_in=4'b1111.
  - Only digit 0 is enabled (d=0, dp=0).
  - dp=1 on all other slots and on all blank cycles.
- Assert reset for 1 cycle during the digit-2 slot.
  - Next cycle: idx=0, cnt=0, an=1111, d=0.
  - Scanning restarts from digit 0.
- Set x=16'hFA00 with lzb=0.
  - d shows 0,0,10,15; codes pass through unmodified.
  - Exactly one an bit is low on every non-blank cycle.
